varshift_feeder: RTL

VARSHIFT_FEEDER -- requirements
Module: varshift_feeder

---
 rtl/varshift_feeder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/varshift_feeder.sv
// Packs 0..3-bit MSB-first symbols into N-bit words held in an external variable shift register.
// Defining VARSHIFT_FEEDER_FLUSH_EN enables zero-padding of a partial word on flush_req.
module varshift_feeder #(
    parameter int unsigned N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sym_valid,
    input  logic [2:0]             sym_data,
    input  logic [1:0]             sym_len,
    output logic                   sym_ready,
    input  logic                   flush_req,
    output logic [1:0]             sh_amount,
    output logic [2:0]             sin,
    output logic                   sr_clr,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [$clog2(N+1)-1:0] fill
);

`ifdef VARSHIFT_FEEDER_FLUSH_EN
    localparam bit FlushEn = 1'b1;
`else
    localparam bit FlushEn = 1'b0;
`endif

    localparam int unsigned FW = $clog2(N + 1);
    typedef logic [FW:0] cnt_t;
    localparam cnt_t NFull = cnt_t'(N);

    typedef enum logic [1:0] {
        StFill,
        StFull,
        StPad
    } state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [1:0]      count_q, count_d;
    logic [1:0][2:0] data_q, data_d;
    logic [1:0][1:0] len_q, len_d;

    logic       have_head;
    logic       push;
    logic       pop;
    logic       trim;
    logic [1:0] shift_amt;
    cnt_t       room;
    cnt_t       fill_sum;

    assign sym_ready  = (count_q < 2'd2);
    assign word_valid = (state_q == StFull);
    assign sr_clr     = ~rst;
    assign fill       = fill_q;
    assign sh_amount  = shift_amt;
    assign sin        = (state_q == StFill && have_head) ? data_q[0] : 3'b000;

    // Shift decision depends only on registered state.
    always_comb begin
        have_head = (count_q != 2'd0);
        room      = NFull - {1'b0, fill_q};
        push      = sym_valid && sym_ready && (sym_len != 2'd0);
        shift_amt = 2'd0;
        pop       = 1'b0;
        trim      = 1'b0;
        unique case (state_q)
            StFill: begin
                if (have_head) begin
                    if (cnt_t'(len_q[0]) <= room) begin
                        shift_amt = len_q[0];
                        pop       = 1'b1;
                    end else begin
                        shift_amt = room[1:0];
                        trim      = 1'b1;
                    end
                end
            end
            StPad:   shift_amt = (room > cnt_t'(3)) ? 2'd3 : room[1:0];
            default: ;
        endcase
        fill_sum = {1'b0, fill_q} + cnt_t'(shift_amt);
    end

    always_comb begin
        data_d  = data_q;
        len_d   = len_q;
        count_d = count_q;
        state_d = state_q;
        fill_d  = fill_q;

        // A partially consumed head keeps its unshifted remainder left-justified.
        if (trim) begin
            data_d[0] = data_q[0] << shift_amt;
            len_d[0]  = len_q[0] - shift_amt;
        end
        if (pop) begin
            data_d[0] = data_q[1];
            len_d[0]  = len_q[1];
            count_d   = count_q - 2'd1;
        end
        if (push) begin
            data_d[count_d[0]] = sym_data;
            len_d[count_d[0]]  = sym_len;
            count_d            = count_d + 2'd1;
        end

        unique case (state_q)
            StFill, StPad: begin
                fill_d = fill_sum[FW-1:0];
                if (fill_sum == NFull) begin
                    state_d = StFull;
                end else if (state_q == StFill && !have_head && FlushEn && flush_req &&
                             fill_q != '0) begin
                    state_d = StPad;
                end
            end
            StFull: begin
                if (word_ready) begin
                    fill_d  = '0;
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFill;
            fill_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            data_q  <= data_d;
            len_q   <= len_d;
        end
    end

endmodule
